// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register-file write path.
//   REG_AW / DATA_W : register address and data widths
//   REG_ZERO        : hardwired-zero register address ($0)
//   wb_req_t        : one writeback request {valid, a3, wd, pc}
package cpu_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] a3;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Late-write buffer: circular FIFO whose entries carry a valid bit that can be
// cleared in place, so a superseded write still pops in order but never
// reaches the register file.
//   clk, rst_n      : clock, async active-low reset (empties the FIFO)
//   i_push/i_push_req : enqueue one request (its valid bit is stored as given)
//   i_pop           : discard the head entry
//   i_inval_mask    : per-slot clear of the valid bit
//   i_cmp_a3        : NCMP addresses compared against every slot
//   o_match         : per-address, per-slot "valid and a3 equal" vector
//   o_head/o_empty/o_count : head entry, empty flag, occupancy
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NCMP  = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_push,
  input  wb_req_t                           i_push_req,
  input  logic                              i_pop,
  input  logic [DEPTH-1:0]                  i_inval_mask,
  input  logic [NCMP-1:0][REG_AW-1:0]       i_cmp_a3,
  output logic [NCMP-1:0][DEPTH-1:0]        o_match,
  output wb_req_t                           o_head,
  output logic                              o_empty,
  output logic [$clog2(DEPTH):0]            o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  w_valid_nxt;
  logic [REG_AW-1:0] r_a3 [DEPTH];
  logic [DATA_W-1:0] r_wd [DEPTH];
  logic [DATA_W-1:0] r_pc [DEPTH];

  // Slots outside the occupied window always hold valid=0, so the match
  // vectors never see stale data. Push runs last: its slot is never occupied.
  always_comb begin
    // NOTE: start combinational blocks from a full default so no path leaves
    // a bit unassigned and infers a latch.
    w_valid_nxt = r_valid & ~i_inval_mask;
    // NOTE: blocking assignments here let later lines override earlier ones
    // within the same evaluation; sequential blocks use <= instead.
    if (i_pop)  w_valid_nxt[r_rd_ptr] = 1'b0;
    if (i_push) w_valid_nxt[r_wr_ptr] = i_push_req.valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: payload storage has no reset; the reset valid bits make its
  // contents irrelevant until each slot is written.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_a3[r_wr_ptr] <= i_push_req.a3;
      r_wd[r_wr_ptr] <= i_push_req.wd;
      r_pc[r_wr_ptr] <= i_push_req.pc;
    end
  end

  always_comb begin
    for (int k = 0; k < NCMP; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        o_match[k][i] = r_valid[i] && (r_a3[i] == i_cmp_a3[k]);
      end
    end
  end

  assign o_head  = '{valid: r_valid[r_rd_ptr], a3: r_a3[r_rd_ptr],
                     wd: r_wd[r_rd_ptr], pc: r_pc[r_rd_ptr]};
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/grf_wb_arb.sv
// Write-side front end of the general register file. Merges the in-order
// W-stage write and buffered late results onto the single GRF write port,
// keeping program order and reporting pending late writes to the hazard unit.
//   clk, rst_n            : clock, async active-low reset
//   pw_wr/pw_a3/pw_wd/pw_pc : pipeline W-stage write (no backpressure)
//   lw_valid/lw_ready/lw_a3/lw_wd/lw_pc : late-write request handshake
//   ra1, ra2              : decode read addresses checked for pending writes
//   pend_hit              : a queued/incoming late write targets ra1 or ra2
//   pw_hold               : FIFO head starved; pipeline must bubble next cycle
//   grf_wr/grf_a3/grf_wd/grf_pc : registered GRF write port (+ trace PC)
module grf_wb_arb
  import cpu_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pw_wr,
  input  logic [REG_AW-1:0] pw_a3,
  input  logic [DATA_W-1:0] pw_wd,
  input  logic [DATA_W-1:0] pw_pc,
  input  logic              lw_valid,
  output logic              lw_ready,
  input  logic [REG_AW-1:0] lw_a3,
  input  logic [DATA_W-1:0] lw_wd,
  input  logic [DATA_W-1:0] lw_pc,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic              pend_hit,
  output logic              pw_hold,
  output logic              grf_wr,
  output logic [REG_AW-1:0] grf_a3,
  output logic [DATA_W-1:0] grf_wd,
  output logic [DATA_W-1:0] grf_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  wb_req_t                    w_head;
  wb_req_t                    w_lw_req;
  logic                       w_empty;
  logic [AW:0]                w_count;
  logic [2:0][REG_AW-1:0]     w_cmp;
  logic [2:0][DEPTH-1:0]      w_match;
  logic                       w_pe;
  logic                       w_accept;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_head_valid;
  logic                       w_head_win;
  logic                       w_head_lose;
  logic                       w_hit1;
  logic                       w_hit2;
  logic [SW-1:0]              r_starve;

  assign w_pe     = pw_wr && (pw_a3 != REG_ZERO);
  assign lw_ready = (w_count != FULL_CNT);
  assign w_accept = lw_valid && lw_ready;
  // $0 late writes complete the handshake but are never stored.
  assign w_push   = w_accept && (lw_a3 != REG_ZERO);

  // A same-cycle pipeline write to the same register is younger, so the
  // late result is stored already cancelled.
  assign w_lw_req = '{valid: !(w_pe && (lw_a3 == pw_a3)), a3: lw_a3,
                      wd: lw_wd, pc: lw_pc};

  // Slot 0 of the compare vector drives cancellation, 1/2 drive pend_hit.
  assign w_cmp = {ra2, ra1, pw_a3};

  assign w_head_valid = !w_empty && w_head.valid;
  assign w_head_win   = w_head_valid && !w_pe;
  assign w_head_lose  = w_head_valid && w_pe;
  // A cancelled head drains without needing the write port.
  assign w_pop        = !w_empty && (!w_head.valid || !w_pe);

  wb_fifo #(
    .DEPTH (DEPTH),
    .NCMP  (3)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_req   (w_lw_req),
    .i_pop        (w_pop),
    .i_inval_mask (w_pe ? w_match[0] : '0),
    .i_cmp_a3     (w_cmp),
    .o_match      (w_match),
    .o_head       (w_head),
    .o_empty      (w_empty),
    .o_count      (w_count)
  );

  // The grf_* register is deliberately excluded: GRF write-through covers it.
  assign w_hit1   = (ra1 != REG_ZERO) && ((|w_match[1]) || (w_push && lw_a3 == ra1));
  assign w_hit2   = (ra2 != REG_ZERO) && ((|w_match[2]) || (w_push && lw_a3 == ra2));
  assign pend_hit = w_hit1 || w_hit2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grf_wr <= 1'b0;
      grf_a3 <= '0;
      grf_wd <= '0;
      grf_pc <= '0;
    end else if (w_pe) begin
      grf_wr <= 1'b1;
      grf_a3 <= pw_a3;
      grf_wd <= pw_wd;
      grf_pc <= pw_pc;
    end else if (w_head_win) begin
      grf_wr <= 1'b1;
      grf_a3 <= w_head.a3;
      grf_wd <= w_head.wd;
      grf_pc <= w_head.pc;
    end else begin
      grf_wr <= 1'b0;
    end
  end

  // Saturates so a pipeline ignoring pw_hold cannot wrap the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_pop) begin
      r_starve <= '0;
    end else if (w_head_lose && (r_starve != STARVE_LIM)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign pw_hold = (r_starve >= STARVE_LIM);

endmodule

// File: tb/tb_grf_wb_arb.sv
// Self-checking bench for grf_wb_arb: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_grf_wb_arb;
  import cpu_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pw_wr = 1'b0;
  logic [REG_AW-1:0] pw_a3 = '0;
  logic [DATA_W-1:0] pw_wd = '0;
  logic [DATA_W-1:0] pw_pc = '0;
  logic              lw_valid = 1'b0;
  logic              lw_ready;
  logic [REG_AW-1:0] lw_a3 = '0;
  logic [DATA_W-1:0] lw_wd = '0;
  logic [DATA_W-1:0] lw_pc = '0;
  logic [REG_AW-1:0] ra1 = '0;
  logic [REG_AW-1:0] ra2 = '0;
  logic              pend_hit;
  logic              pw_hold;
  logic              grf_wr;
  logic [REG_AW-1:0] grf_a3;
  logic [DATA_W-1:0] grf_wd;
  logic [DATA_W-1:0] grf_pc;

  always #5 clk = ~clk;

  grf_wb_arb #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pw_wr    (pw_wr),
    .pw_a3    (pw_a3),
    .pw_wd    (pw_wd),
    .pw_pc    (pw_pc),
    .lw_valid (lw_valid),
    .lw_ready (lw_ready),
    .lw_a3    (lw_a3),
    .lw_wd    (lw_wd),
    .lw_pc    (lw_pc),
    .ra1      (ra1),
    .ra2      (ra2),
    .pend_hit (pend_hit),
    .pw_hold  (pw_hold),
    .grf_wr   (grf_wr),
    .grf_a3   (grf_a3),
    .grf_wd   (grf_wd),
    .grf_pc   (grf_pc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of pending late writes (oldest first), starvation
  // count, and the write expected on the GRF port after the next edge.
  wb_req_t     mq[$];
  int          m_starve = 0;
  logic        m_wr = 1'b0;
  logic [4:0]  m_a3 = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] m_pc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: called just after a falling edge, returns at the next one.
  task automatic cycle(input logic wr, input logic [4:0] pa3, input logic [31:0] pwd,
                       input logic lv, input logic [4:0] la3, input logic [31:0] lwd,
                       input logic [4:0] r1, input logic [4:0] r2);
    logic pe, ready, acc, hit;
    pw_wr = wr;  pw_a3 = pa3;  pw_wd = pwd;  pw_pc = $urandom;
    lw_valid = lv; lw_a3 = la3; lw_wd = lwd; lw_pc = $urandom;
    ra1 = r1; ra2 = r2;
    #1;
    ready = (mq.size() != DEPTH);
    acc   = lv && ready;
    hit   = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].valid && ((r1 != 0 && mq[i].a3 == r1) || (r2 != 0 && mq[i].a3 == r2))) hit = 1'b1;
    end
    if (acc && la3 != 0 && (la3 == r1 || la3 == r2)) hit = 1'b1;
    check("lw_ready", {31'b0, lw_ready}, {31'b0, ready});
    check("pend_hit", {31'b0, pend_hit}, {31'b0, hit});
    check("pw_hold", {31'b0, pw_hold}, {31'b0, m_starve >= STARVE_MAX});

    pe   = wr && (pa3 != 0);
    m_wr = 1'b0;
    if (pe) begin
      m_wr = 1'b1; m_a3 = pa3; m_wd = pwd; m_pc = pw_pc;
    end
    if (mq.size() > 0) begin
      if (!mq[0].valid) begin
        void'(mq.pop_front());
        m_starve = 0;
      end else if (!pe) begin
        m_wr = 1'b1; m_a3 = mq[0].a3; m_wd = mq[0].wd; m_pc = mq[0].pc;
        void'(mq.pop_front());
        m_starve = 0;
      end else if (m_starve < STARVE_MAX) begin
        m_starve++;
      end
    end
    if (pe) begin
      foreach (mq[i]) if (mq[i].a3 == pa3) mq[i].valid = 1'b0;
    end
    if (acc && la3 != 0) begin
      mq.push_back('{valid: !(pe && la3 == pa3), a3: la3, wd: lwd, pc: lw_pc});
    end

    @(posedge clk);
    #1;
    check("grf_wr", {31'b0, grf_wr}, {31'b0, m_wr});
    if (m_wr) begin
      check("grf_a3", {27'b0, grf_a3}, {27'b0, m_a3});
      check("grf_wd", grf_wd, m_wd);
      check("grf_pc", grf_pc, m_pc);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [4:0] r1);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, 5'd0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    pw_wr = 1'b0; lw_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_grf_wr", {31'b0, grf_wr}, 32'd0);
    check("rst_grf_a3", {27'b0, grf_a3}, 32'd0);
    check("rst_grf_wd", grf_wd, 32'd0);
    check("rst_grf_pc", grf_pc, 32'd0);
    check("rst_pw_hold", {31'b0, pw_hold}, 32'd0);
    mq.delete();
    m_starve = 0;
    m_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_lw_ready", {31'b0, lw_ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic wr, lv;
    // Power-up reset.
    repeat (2) @(negedge clk);
    #1;
    check("init_grf_wr", {31'b0, grf_wr}, 32'd0);
    check("init_pw_hold", {31'b0, pw_hold}, 32'd0);
    check("init_grf_wd", grf_wd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single late write reaches the GRF after one queued cycle.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11, 5'd5, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle(2, 5'd5);

    // Fill FIFO under constant pipeline writes; starvation then one bubble.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd10 + 5'(i % 4), 32'h200 + i, 5'd10, 5'd13);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd0);
    idle(4, 5'd11);

    // Pipeline write supersedes a queued late write to the same register.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA, 5'd7, 5'd0);
    cycle(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    idle(3, 5'd7);

    // Same-cycle late and pipeline writes to $9: only the pipeline value lands.
    cycle(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
    idle(3, 5'd9);

    // Writes to $0 are handshaken and dropped.
    cycle(1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 32'h6, 5'd0, 5'd0);
    idle(2, 5'd0);

    // Reset with three entries queued behind pipeline writes.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 5'd2, 32'h300 + i, 1'b1, 5'd20 + 5'(i), 32'h400 + i, 5'd20, 5'd0);
    end
    mid_reset();
    idle(4, 5'd20);

    // Random traffic on a small register range to force collisions.
    for (int n = 0; n < 600; n++) begin
      wr = ($urandom_range(0, 2) != 0) && (m_starve < STARVE_MAX);
      lv = ($urandom_range(0, 1) != 0);
      cycle(wr, 5'($urandom_range(0, 7)), $urandom, lv, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (n % 200 == 199) mid_reset();
    end
    idle(6, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
